// File: rtl/if_prefetch.sv
// Instruction-fetch stage: owns the fetch PC, keeps at most one memory request
// in flight and buffers returned words with their PCs in a FIFO toward ID.
module if_prefetch #(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] flush_pc_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [INST_W-1:0] mem_rdata_i,
  input  logic              id_ready_i,
  output logic              valid_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [INST_W-1:0] inst_o,
  output logic              stall_req_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL        = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ALMOST_FULL = CNT_W'(DEPTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DROP = 2'd2;

  logic [1:0]        state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] req_pc;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];

  logic req;
  logic grant;
  logic push;
  logic pop;
  logic valid;
  logic unused_flush_lsbs;

  // In WAIT a new request only goes out alongside the response, and it must
  // leave room for that response plus its own.
  always_comb begin
    req = 1'b0;
    if (!rst && !flush_i) begin
      if (state == IDLE) begin
        req = (count < FULL);
      end else if (state == WAIT) begin
        req = mem_rvalid_i && (count < ALMOST_FULL);
      end
    end
  end

  assign grant = req && mem_gnt_i;
  assign push  = (state == WAIT) && mem_rvalid_i && !flush_i;
  assign valid = (count != '0) && !flush_i;
  assign pop   = valid && id_ready_i;

  assign unused_flush_lsbs = ^flush_pc_i[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else if (flush_i) begin
      fetch_pc <= {flush_pc_i[ADDR_W-1:2], 2'b00};
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      // A response still owed by memory must be swallowed before refetching.
      case (state)
        WAIT, DROP: state <= mem_rvalid_i ? IDLE : DROP;
        default:    state <= IDLE;
      endcase
    end else begin
      if (grant) fetch_pc <= fetch_pc + ADDR_W'(4);
      if (push)  wr_ptr   <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr   <= rd_ptr + PTR_W'(1);
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
      case (state)
        IDLE:    if (grant) state <= WAIT;
        WAIT:    if (mem_rvalid_i) state <= grant ? WAIT : IDLE;
        DROP:    if (mem_rvalid_i) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (grant) req_pc <= fetch_pc;
    if (push) begin
      pc_mem[wr_ptr]   <= req_pc;
      inst_mem[wr_ptr] <= mem_rdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && (count == FULL)));
    end
  end

  assign mem_req_o   = req;
  assign mem_addr_o  = fetch_pc;
  assign valid_o     = valid;
  assign pc_o        = valid ? pc_mem[rd_ptr]   : '0;
  assign inst_o      = valid ? inst_mem[rd_ptr] : '0;
  assign stall_req_o = !valid;

endmodule

// File: tb/tb_if_prefetch.sv
// Bench for if_prefetch: a one-outstanding memory responder plus a model of the
// expected fetch stream (sequential PCs from the last redirect) and FIFO occupancy.
module tb_if_prefetch;

  localparam int          ADDR_W   = 32;
  localparam int          INST_W   = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] KEY      = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush_i = 1'b0;
  logic [31:0] flush_pc_i = '0;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        id_ready_i = 1'b0;
  logic        valid_o;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        stall_req_o;

  always #5 clk = ~clk;

  if_prefetch #(
    .ADDR_W(ADDR_W), .INST_W(INST_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .flush_pc_i(flush_pc_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .id_ready_i(id_ready_i), .valid_o(valid_o), .pc_o(pc_o), .inst_o(inst_o),
    .stall_req_o(stall_req_o)
  );

  int vectors = 0;
  int miscompares = 0;

  // stimulus knobs
  int gnt_mode = 1;
  int dmin = 0;
  int dmax = 0;
  bit stray = 1'b0;

  // memory responder and reference model
  bit          outstanding = 1'b0;
  bit          out_live = 1'b0;
  logic [31:0] out_addr = '0;
  int          out_delay = 0;
  int          occ = 0;
  logic [31:0] head_pc = RESET_PC;
  logic [31:0] next_addr = RESET_PC;
  int          grants = 0;
  int          pops = 0;
  bit          seen_pop = 1'b0;
  logic [31:0] first_pop_pc = '0;

  // values sampled in the last cycle
  logic        s_req;
  logic        s_valid;
  logic [31:0] s_addr;
  logic [31:0] s_pc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    bit resp, exp_req, exp_valid, grant, pop;
    @(negedge clk);
    resp         = outstanding && (out_delay == 0);
    mem_rvalid_i = resp || (stray && !outstanding);
    mem_rdata_i  = resp ? (out_addr ^ KEY) : $urandom;
    case (gnt_mode)
      0:       mem_gnt_i = 1'b0;
      1:       mem_gnt_i = 1'b1;
      default: mem_gnt_i = ($urandom_range(3) != 0);
    endcase
    #1;
    s_req   = mem_req_o;
    s_addr  = mem_addr_o;
    s_valid = valid_o;
    s_pc    = pc_o;
    exp_valid = !rst && (occ != 0) && !flush_i;
    if (rst) begin
      chk("req_in_rst", mem_req_o, 0);
    end else begin
      exp_req = !flush_i && ((!outstanding && occ < DEPTH) ||
                             (outstanding && out_live && resp && occ < DEPTH - 1));
      chk("req", mem_req_o, exp_req);
      if (exp_req) chk("addr", mem_addr_o, next_addr);
      chk("valid", valid_o, exp_valid);
      chk("stall", stall_req_o, !exp_valid);
      chk("pc", pc_o, exp_valid ? head_pc : 32'h0);
      chk("inst", inst_o, exp_valid ? (head_pc ^ KEY) : 32'h0);
    end
    grant = mem_req_o && mem_gnt_i;
    pop   = exp_valid && id_ready_i;
    @(posedge clk);
    #1;
    if (rst) begin
      outstanding = 1'b0;
      out_live    = 1'b0;
      occ         = 0;
      head_pc     = RESET_PC;
      next_addr   = RESET_PC;
    end else if (flush_i) begin
      occ       = 0;
      next_addr = {flush_pc_i[31:2], 2'b00};
      head_pc   = next_addr;
      if (resp) begin
        outstanding = 1'b0;
      end else if (outstanding) begin
        out_live = 1'b0;
        if (out_delay > 0) out_delay--;
      end
    end else begin
      if (resp) begin
        if (out_live) occ++;
        outstanding = 1'b0;
      end
      if (pop) begin
        occ--;
        head_pc += 4;
        pops++;
        if (!seen_pop) begin
          seen_pop     = 1'b1;
          first_pop_pc = s_pc;
        end
      end
      if (grant) begin
        outstanding = 1'b1;
        out_live    = 1'b1;
        out_addr    = s_addr;
        out_delay   = $urandom_range(dmax, dmin);
        next_addr  += 4;
        grants++;
      end else if (outstanding && out_delay > 0) begin
        out_delay--;
      end
    end
  endtask

  initial begin
    // reset and first fetch with zero-wait memory
    rst = 1'b1; id_ready_i = 1'b1;
    tick(); tick();
    rst = 1'b0; grants = 0; pops = 0;
    tick();
    chk("first_req", s_req, 1);
    chk("first_addr", s_addr, RESET_PC);
    chk("first_valid", s_valid, 0);
    repeat (11) tick();
    chk("throughput", pops, 10);

    // backpressure fills the FIFO, then drains in order
    rst = 1'b1; tick();
    rst = 1'b0; grants = 0; id_ready_i = 1'b0;
    repeat (10) tick();
    chk("bp_grants", grants, 4);
    chk("bp_req_idle", s_req, 0);
    chk("bp_head", s_pc, 32'h0);
    id_ready_i = 1'b1;
    repeat (12) tick();

    // flush while a slow response is in flight
    rst = 1'b1; tick();
    rst = 1'b0; id_ready_i = 1'b1;
    tick(); tick();
    dmin = 3; dmax = 3; tick();
    dmin = 0; dmax = 0; flush_i = 1'b1; flush_pc_i = 32'h103; tick();
    chk("flush_valid", s_valid, 0);
    flush_i = 1'b0; seen_pop = 1'b0;
    repeat (10) tick();
    chk("drop_first_pc", first_pop_pc, 32'h100);

    // flush in the same cycle as the response for 0x4
    rst = 1'b1; tick();
    rst = 1'b0;
    tick(); tick();
    flush_i = 1'b1; flush_pc_i = 32'h40; tick();
    flush_i = 1'b0; tick();
    chk("post_flush_req", s_req, 1);
    chk("post_flush_addr", s_addr, 32'h40);
    chk("post_flush_valid", s_valid, 0);
    repeat (6) tick();

    // push and pop together at count 3, then flush with ID ready
    rst = 1'b1; tick();
    rst = 1'b0; id_ready_i = 1'b0;
    repeat (4) tick();
    id_ready_i = 1'b1; tick();
    chk("pp_pc0", s_pc, 32'h0);
    tick();
    chk("pp_pc1", s_pc, 32'h4);
    flush_i = 1'b1; flush_pc_i = 32'h200; tick();
    chk("flush_no_pop", s_valid, 0);
    flush_i = 1'b0;
    repeat (6) tick();

    // reset mid-operation, then a stray response
    rst = 1'b1; tick();
    rst = 1'b0; id_ready_i = 1'b0;
    repeat (3) tick();
    rst = 1'b1; tick();
    rst = 1'b0; gnt_mode = 0; stray = 1'b1; tick();
    chk("rst_mid_valid", s_valid, 0);
    chk("rst_mid_addr", s_addr, RESET_PC);
    chk("rst_mid_pc", s_pc, 32'h0);
    stray = 1'b0; tick();
    chk("stray_ignored", s_valid, 0);
    gnt_mode = 1; id_ready_i = 1'b1;
    repeat (4) tick();

    // randomized traffic
    rst = 1'b1; tick();
    rst = 1'b0; gnt_mode = 2; dmin = 0; dmax = 3;
    for (int i = 0; i < 3000; i++) begin
      id_ready_i = ($urandom_range(3) != 0);
      flush_i    = ($urandom_range(39) == 0);
      flush_pc_i = ($urandom_range(1) != 0) ? $urandom : (32'hFFFF_FFE0 | $urandom_range(31));
      stray      = ($urandom_range(9) == 0);
      rst        = ($urandom_range(299) == 0);
      tick();
    end
    rst = 1'b0; flush_i = 1'b0; stray = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
